psum_reduce_tree: RTL and testbench



---
 rtl/psum_reduce_tree.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_psum_reduce_tree.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_reduce_tree.sv
// psum_reduce_tree
// ----------------
// Column-reduction stage between the PE column FIFOs and the per-row fm/guard
// generator. It joins N_COL partial-sum streams with a valid/ready handshake
// and sums the enabled columns lane by lane through a registered signed adder
// tree of clog2(N_COL) stages. The tree sums are accumulated over the beats of
// a pass, and one saturated result is emitted per pass, with backpressure.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   col_en_i     [N_COL]  column enable mask, sampled at each join
//   in_valid_i   [N_COL]  per-column beat valid
//   in_ready_o   [N_COL]  per-column beat accepted (col_en_i & fire)
//   in_data_i    [N_COL*LANES*PSUM_WIDTH]  signed psums; column j, lane l at
//                bit offset (j*LANES+l)*PSUM_WIDTH
//   acc_first_i  beat starts a pass (accumulator is overwritten)
//   acc_last_i   beat ends a pass (result is emitted)
//   out_valid_o  result valid
//   out_ready_i  downstream ready
//   out_data_o   [LANES*OUT_WIDTH]  saturated result; lane l at l*OUT_WIDTH
//   out_sat_o    [LANES]  lane saturated at any point in the pass
//   busy_o       a beat is in flight or a pass is open
module psum_reduce_tree #(
  parameter int N_COL      = 4,
  parameter int LANES      = 18,
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_COL-1:0]                  col_en_i,
  input  logic [N_COL-1:0]                  in_valid_i,
  output logic [N_COL-1:0]                  in_ready_o,
  input  logic [N_COL*LANES*PSUM_WIDTH-1:0] in_data_i,
  input  logic                              acc_first_i,
  input  logic                              acc_last_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [LANES*OUT_WIDTH-1:0]        out_data_o,
  output logic [LANES-1:0]                  out_sat_o,
  output logic                              busy_o
);

  localparam int T  = (N_COL > 1) ? $clog2(N_COL) : 0;
  localparam int SW = PSUM_WIDTH + T;   // tree width: the full column sum cannot overflow
  localparam int TD = (T > 0) ? T : 1;  // storage depth, kept >= 1 so arrays stay legal

  // Adding two ACC_WIDTH values overflowed iff the top two bits of the sum differ.
  function automatic logic acc_clamps(input logic signed [ACC_WIDTH:0] v);
    return v[ACC_WIDTH] ^ v[ACC_WIDTH-1];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_to_acc(input logic signed [ACC_WIDTH:0] v);
    if (acc_clamps(v)) begin
      if (v[ACC_WIDTH]) begin
        return {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        return {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      return v[ACC_WIDTH-1:0];
    end
  endfunction

  // A value fits OUT_WIDTH iff every bit above the output sign bit copies it.
  function automatic logic out_clips(input logic signed [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-OUT_WIDTH:0] top;
    top = a[ACC_WIDTH-1:OUT_WIDTH-1];
    return ~((&top) | ~(|top));
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_to_out(input logic signed [ACC_WIDTH-1:0] a);
    if (out_clips(a)) begin
      if (a[ACC_WIDTH-1]) begin
        return {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        return {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else begin
      return a[OUT_WIDTH-1:0];
    end
  endfunction

  logic adv_s;
  logic fire_s;

  // lvl_s[0] is the masked join input; lvl_s[s+1] is the output of tree register s.
  logic signed [SW-1:0] lvl_s  [T+1][N_COL][LANES];
  logic signed [SW-1:0] tree_d [TD][N_COL][LANES];
  logic signed [SW-1:0] tree_q [TD][N_COL][LANES];
  logic [TD-1:0] tv_d, tv_q;  // per-stage beat valid
  logic [TD-1:0] tf_d, tf_q;  // per-stage acc_first
  logic [TD-1:0] tl_d, tl_q;  // per-stage acc_last

  logic st_v_s, st_f_s, st_l_s;  // beat arriving at the accumulate stage

  logic signed [ACC_WIDTH-1:0] acc_d [LANES];
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];
  logic [LANES-1:0]            sticky_d, sticky_q;
  logic [LANES*OUT_WIDTH-1:0]  out_data_d, out_data_q;
  logic [LANES-1:0]            out_sat_d, out_sat_q;
  logic                        out_valid_d, out_valid_q;
  logic                        acc_v_d, acc_v_q;
  logic                        pass_open_d, pass_open_q;

  // The whole pipeline stalls together while a result waits downstream.
  assign adv_s      = ~out_valid_q | out_ready_i;
  assign fire_s     = adv_s & (|col_en_i) & (&(in_valid_i | ~col_en_i));
  assign in_ready_o = fire_s ? col_en_i : {N_COL{1'b0}};

  // Build the tree level inputs: masked, sign-extended columns, then each stage.
  always_comb begin
    for (int j = 0; j < N_COL; j++) begin
      for (int l = 0; l < LANES; l++) begin
        if (col_en_i[j]) begin
          lvl_s[0][j][l] = SW'($signed(in_data_i[(j*LANES+l)*PSUM_WIDTH +: PSUM_WIDTH]));
        end else begin
          lvl_s[0][j][l] = '0;
        end
      end
    end
    for (int s = 0; s < T; s++) begin
      for (int j = 0; j < N_COL; j++) begin
        for (int l = 0; l < LANES; l++) begin
          lvl_s[s+1][j][l] = tree_q[s][j][l];
        end
      end
    end
  end

  // Pairwise-add stages; an odd trailing operand is carried through registered.
  always_comb begin
    int n_ops;
    int ia;
    int ib;
    n_ops = 0;
    ia    = 0;
    ib    = 0;
    for (int s = 0; s < TD; s++) begin
      for (int k = 0; k < N_COL; k++) begin
        for (int l = 0; l < LANES; l++) begin
          tree_d[s][k][l] = tree_q[s][k][l];
        end
      end
    end
    tv_d = tv_q;
    tf_d = tf_q;
    tl_d = tl_q;
    if (adv_s && (T > 0)) begin
      for (int s = 0; s < T; s++) begin
        n_ops = (N_COL + (1 << s) - 1) >> s;
        for (int k = 0; k < N_COL; k++) begin
          ia = (2*k < N_COL) ? 2*k : 0;
          ib = (2*k + 1 < N_COL) ? 2*k + 1 : 0;
          for (int l = 0; l < LANES; l++) begin
            if (2*k + 1 < n_ops) begin
              tree_d[s][k][l] = lvl_s[s][ia][l] + lvl_s[s][ib][l];
            end else if (2*k < n_ops) begin
              tree_d[s][k][l] = lvl_s[s][ia][l];
            end else begin
              tree_d[s][k][l] = '0;
            end
          end
        end
      end
      tv_d[0] = fire_s;
      tf_d[0] = acc_first_i;
      tl_d[0] = acc_last_i;
      for (int s = 1; s < TD; s++) begin
        tv_d[s] = tv_q[s-1];
        tf_d[s] = tf_q[s-1];
        tl_d[s] = tl_q[s-1];
      end
    end else begin
      tv_d = tv_q;
    end
  end

  if (T == 0) begin : g_direct
    assign st_v_s = fire_s;
    assign st_f_s = acc_first_i;
    assign st_l_s = acc_last_i;
  end else begin : g_tree
    assign st_v_s = tv_q[T-1];
    assign st_f_s = tf_q[T-1];
    assign st_l_s = tl_q[T-1];
  end

  // Accumulate the tree sum per lane; on the last beat load the output register.
  always_comb begin
    logic signed [ACC_WIDTH:0]   wide;
    logic signed [ACC_WIDTH-1:0] nxt;
    logic                        stk;
    wide = '0;
    nxt  = '0;
    stk  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
    end
    sticky_d    = sticky_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    acc_v_d     = acc_v_q;
    pass_open_d = pass_open_q;
    if (adv_s) begin
      out_valid_d = st_v_s & st_l_s;
      acc_v_d     = st_v_s;
      pass_open_d = fire_s ? ~acc_last_i : pass_open_q;
      if (st_v_s) begin
        for (int l = 0; l < LANES; l++) begin
          // A first beat overwrites, i.e. adds onto zero with a clean sticky flag.
          if (st_f_s) begin
            wide = (ACC_WIDTH+1)'(lvl_s[T][0][l]);
            stk  = 1'b0;
          end else begin
            wide = (ACC_WIDTH+1)'(acc_q[l]) + (ACC_WIDTH+1)'(lvl_s[T][0][l]);
            stk  = sticky_q[l];
          end
          nxt = sat_to_acc(wide);
          stk = stk | acc_clamps(wide);
          if (st_l_s) begin
            out_data_d[l*OUT_WIDTH +: OUT_WIDTH] = sat_to_out(nxt);
            out_sat_d[l] = stk | out_clips(nxt);
            acc_d[l]     = '0;
            sticky_d[l]  = 1'b0;
          end else begin
            acc_d[l]    = nxt;
            sticky_d[l] = stk;
          end
        end
      end else begin
        sticky_d = sticky_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < TD; s++) begin
        for (int k = 0; k < N_COL; k++) begin
          for (int l = 0; l < LANES; l++) begin
            tree_q[s][k][l] <= '0;
          end
        end
      end
      tv_q <= '0;
      tf_q <= '0;
      tl_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
      sticky_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      out_valid_q <= 1'b0;
      acc_v_q     <= 1'b0;
      pass_open_q <= 1'b0;
    end else begin
      for (int s = 0; s < TD; s++) begin
        for (int k = 0; k < N_COL; k++) begin
          for (int l = 0; l < LANES; l++) begin
            tree_q[s][k][l] <= tree_d[s][k][l];
          end
        end
      end
      tv_q <= tv_d;
      tf_q <= tf_d;
      tl_q <= tl_d;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
      sticky_q    <= sticky_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      acc_v_q     <= acc_v_d;
      pass_open_q <= pass_open_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign busy_o      = (|tv_q) | acc_v_q | pass_open_q;

endmodule

// File: tb/tb_psum_reduce_tree.sv
// Directed bench for psum_reduce_tree (N_COL=4, LANES=2, PSUM_WIDTH=8,
// ACC_WIDTH=12, OUT_WIDTH=10). A pass-level model turns every accepted beat
// into an expected result; a monitor compares the DUT against it each cycle,
// and each directed test pins the model with hand-computed literals.
module tb_psum_reduce_tree;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_en;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] in_data;
  logic        a_first;
  logic        a_last;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [1:0]  out_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d0;
    int         d1;
    logic [1:0] sat;
  } res_t;

  res_t       mq[$];          // expected results, oldest first
  int         pop0[$];        // model results already handed over
  int         pop1[$];
  logic [1:0] popsat[$];
  int         m_acc[2];
  int         m_stk[2];

  psum_reduce_tree #(
    .N_COL(4), .LANES(2), .PSUM_WIDTH(8), .ACC_WIDTH(12), .OUT_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_en_i(col_en), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_data_i(in_data), .acc_first_i(a_first),
    .acc_last_i(a_last), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_sat_o(out_sat), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int b0, input int b1, input int b2, input int b3);
    logic [63:0] r;
    r = {8'(b3), 8'(a3), 8'(b2), 8'(a2), 8'(b1), 8'(a1), 8'(b0), 8'(a0)};
    return r;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Pass-level model and per-cycle comparison.
  always @(negedge clk) begin : mon
    int s;
    int e_rdy;
    int lane_v;
    logic e_fire;
    res_t r;
    logic prev_stall;
    logic [19:0] prev_data;
    logic [1:0] prev_sat;
    if (!rst_n) begin
      mq.delete();
      m_acc[0] = 0; m_acc[1] = 0; m_stk[0] = 0; m_stk[1] = 0;
      prev_stall = 1'b0;
    end else begin
      e_fire = (!out_valid || out_ready) && (col_en != 4'h0) && ((in_valid | ~col_en) == 4'hF);
      e_rdy  = e_fire ? int'(col_en) : 0;
      chk("in_ready", int'(in_ready), e_rdy);
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_data));
        chk("hold_sat", int'(out_sat), int'(prev_sat));
      end
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("out_lane0", int'($signed(out_data[9:0])), mq[0].d0);
          chk("out_lane1", int'($signed(out_data[19:10])), mq[0].d1);
          chk("out_sat", int'(out_sat), int'(mq[0].sat));
          if (out_ready) begin
            r = mq.pop_front();
            pop0.push_back(r.d0);
            pop1.push_back(r.d1);
            popsat.push_back(r.sat);
          end
        end
      end
      if (e_fire) begin
        for (int l = 0; l < 2; l++) begin
          s = 0;
          for (int j = 0; j < 4; j++) begin
            if (col_en[j]) s += int'($signed(in_data[(2*j+l)*8 +: 8]));
          end
          if (a_first) begin
            m_acc[l] = s;
            m_stk[l] = 0;
          end else begin
            m_acc[l] += s;
            if (m_acc[l] > 2047 || m_acc[l] < -2048) m_stk[l] = 1;
            m_acc[l] = clampi(m_acc[l], -2048, 2047);
          end
          if (a_last) begin
            lane_v = clampi(m_acc[l], -512, 511);
            if (l == 0) r.d0 = lane_v; else r.d1 = lane_v;
            r.sat[l] = (m_stk[l] != 0) || (lane_v != m_acc[l]);
            m_acc[l] = 0;
            m_stk[l] = 0;
          end
        end
        if (a_last) mq.push_back(r);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
    end
  end

  task automatic beat(input logic [3:0] en, input logic [63:0] d, input logic f, input logic l);
    bit got;
    got = 1'b0;
    col_en = en; in_valid = en; in_data = d; a_first = f; a_last = l;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready == en) got = 1'b1;
    end
    if (!got) chk("beat_accept_timeout", int'(in_ready), int'(en));
    @(posedge clk); #1;
    in_valid = 4'h0; a_first = 1'b0; a_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!out_valid && mq.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", mq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n0;
    int lat;
    rst_n = 1'b0; col_en = 4'h0; in_valid = 4'h0; in_data = 64'h0;
    a_first = 1'b0; a_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1;

    // Single beat, latency T+1 = 3.
    beat(4'hF, pk(1, 2, 3, 4, -1, -2, -3, -4), 1'b1, 1'b1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    chk("latency", lat, 3);
    wait_idle();
    chk("single_lane0", pop0[pop0.size()-1], 10);
    chk("single_lane1", pop1[pop1.size()-1], -10);
    chk("single_sat", int'(popsat[popsat.size()-1]), 0);

    // Join skew: column 2 late by five cycles.
    n0 = pop0.size();
    col_en = 4'hF; in_valid = 4'b1011; in_data = pk(10, 20, 30, 40, 0, 0, 0, 0);
    a_first = 1'b1; a_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("skew_ready_wait", int'(in_ready), 0);
    end
    @(posedge clk); #1 in_valid = 4'hF;
    @(negedge clk);
    chk("skew_ready_all", int'(in_ready), 15);
    @(posedge clk); #1 in_valid = 4'h0; a_first = 1'b0; a_last = 1'b0;
    wait_idle();
    chk("skew_count", pop0.size() - n0, 1);
    chk("skew_lane0", pop0[pop0.size()-1], 100);

    // Three-beat pass.
    n0 = pop0.size();
    beat(4'hF, pk(25, 25, 25, 25, 1, 1, 1, 1), 1'b1, 1'b0);
    chk("pass3_busy_b1", int'(busy), 1);
    beat(4'hF, pk(25, 25, 25, 25, 1, 1, 1, 1), 1'b0, 1'b0);
    chk("pass3_busy_b2", int'(busy), 1);
    beat(4'hF, pk(25, 25, 25, 25, 1, 1, 1, 1), 1'b0, 1'b1);
    wait_idle();
    chk("pass3_count", pop0.size() - n0, 1);
    chk("pass3_lane0", pop0[pop0.size()-1], 300);
    chk("pass3_lane1", pop1[pop1.size()-1], 12);
    chk("pass3_busy_idle", int'(busy), 0);

    // Saturation at the output width, then a clean pass.
    beat(4'hF, pk(127, 127, 127, 127, 0, 0, 0, 0), 1'b1, 1'b0);
    beat(4'hF, pk(127, 127, 127, 127, 0, 0, 0, 0), 1'b0, 1'b1);
    wait_idle();
    chk("satpos_lane0", pop0[pop0.size()-1], 511);
    chk("satpos_sat", int'(popsat[popsat.size()-1]), 1);
    beat(4'hF, pk(-128, -128, -128, -128, 0, 0, 0, 0), 1'b1, 1'b0);
    beat(4'hF, pk(-128, -128, -128, -128, 0, 0, 0, 0), 1'b0, 1'b1);
    wait_idle();
    chk("satneg_lane0", pop0[pop0.size()-1], -512);
    chk("satneg_sat", int'(popsat[popsat.size()-1]), 1);
    beat(4'hF, pk(5, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    wait_idle();
    chk("after_sat_lane0", pop0[pop0.size()-1], 5);
    chk("after_sat_sat", int'(popsat[popsat.size()-1]), 0);

    // Backpressure: four single-beat passes with downstream stalled six cycles.
    n0 = pop0.size();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) beat(4'h1, pk(i, 0, 0, 0, -i, 0, 0, 0), 1'b1, 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_stall_ready", int'(in_ready), 0);
        chk("bp_stall_valid", int'(out_valid), 1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_count", pop0.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_lane0", pop0[n0+i], i + 1);
      chk("bp_order_lane1", pop1[n0+i], -(i + 1));
    end

    // Column mask: disabled columns carry junk and never go valid.
    beat(4'b0101, pk(7, 55, 9, -33, 1, 100, 2, 100), 1'b1, 1'b1);
    wait_idle();
    chk("mask_lane0", pop0[pop0.size()-1], 16);
    chk("mask_lane1", pop1[pop1.size()-1], 3);

    // Reset mid-pass discards the partial sum.
    n0 = pop0.size();
    beat(4'hF, pk(50, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_output", int'(out_valid), 0);
    end
    chk("rst_busy_clear", int'(busy), 0);
    chk("rst_count", pop0.size() - n0, 0);
    @(posedge clk); #1;
    beat(4'hF, pk(1, 1, 1, 1, 0, 0, 0, 0), 1'b0, 1'b1);
    wait_idle();
    chk("post_rst_count", pop0.size() - n0, 1);
    chk("post_rst_lane0", pop0[pop0.size()-1], 4);

    chk("queue_empty", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
